// File: rtl/nn_dense_layer_pkg.sv
// rtl/nn_dense_layer_pkg.sv - shared types and arithmetic helpers for the dense layer engine
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest accumulator the rescale helper accepts; lanes sign-extend into it
  localparam int MAX_ACC_W = 96;

  // Ceiling log2 that never returns 0, so 1-entry structures still get a 1-bit index
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

  // Full-precision accumulator: product width plus growth for N_IN summands
  function automatic int acc_width(input int w, input int n_in);
    return 2 * w + clog2_min1(n_in);
  endfunction

  // Rescale by an arithmetic shift (floor), clamp to the signed W-bit range, then optional ReLU
  function automatic logic signed [MAX_ACC_W-1:0] sat_relu(
    input logic signed [MAX_ACC_W-1:0] acc,
    input int                          frac,
    input int                          w,
    input logic                        relu
  );
    logic signed [MAX_ACC_W-1:0] r;
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    logic signed [MAX_ACC_W-1:0] one;
    one = MAX_ACC_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    r   = acc >>> frac;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    if (relu && r[MAX_ACC_W-1]) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/nn_dense_layer_if.sv
// rtl/nn_dense_layer_if.sv - weight-write, input-vector and result-vector signals of one layer
interface nn_dense_layer_if #(
  parameter int W     = 16,
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
) ();
  import nn_pkg::*;

  localparam int AW = clog2_min1(N_IN * N_OUT);

  logic                   w_wr_en;
  logic [AW-1:0]          w_addr;
  logic [W-1:0]           w_data;
  logic                   w_wr_err;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_IN*W-1:0]      in_data;
  logic                   relu_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_OUT*W-1:0]     out_data;
  logic                   busy;

  // Upstream / host side
  modport master (
    output w_wr_en, w_addr, w_data, in_valid, in_data, relu_en, out_ready,
    input  w_wr_err, in_ready, out_valid, out_data, busy
  );

  // Layer engine side
  modport slave (
    input  w_wr_en, w_addr, w_data, in_valid, in_data, relu_en, out_ready,
    output w_wr_err, in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/nn_dense_layer_mac_lane.sv
// rtl/nn_dense_layer_mac_lane.sv - one output neuron: accumulator plus rescale/saturate/ReLU
module nn_mac_lane
  import nn_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 0,
  parameter int N_IN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic                i_relu,
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_w,
  output logic signed [W-1:0] o_y_out
);

  localparam int ACC_W = acc_width(W, N_IN);

  logic signed [2*W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod    = i_x * i_w;
  assign w_acc_nxt = i_en ? r_acc + ACC_W'(w_prod) : r_acc;

  // Accumulate one product per MAC cycle; a new vector clears it on its acceptance edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_nxt;
    end
  end

  // Result is taken from the next-state sum so the final product is included on the last MAC edge
  assign o_y_out = W'(sat_relu(MAX_ACC_W'(w_acc_nxt), FRAC, W, i_relu));

endmodule

// File: rtl/nn_dense_layer.sv
// rtl/nn_dense_layer.sv - fully-connected layer: N_OUT parallel MAC lanes stepping over N_IN inputs
module nn_dense_layer
  import nn_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = 0,
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  nn_dense_layer_if.slave bus
);

  localparam int NW = N_IN * N_OUT;
  localparam int AW = clog2_min1(NW);
  localparam int IW = clog2_min1(N_IN);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_live;
  logic                   r_relu;
  logic                   r_wr_err;
  logic [IW-1:0]          r_idx;
  logic signed [W-1:0]    r_x [N_IN];
  logic signed [W-1:0]    r_w [NW];
  logic [N_OUT*W-1:0]     r_out_data;
  logic                   w_in_ready;
  logic                   w_busy;
  logic                   w_out_valid;
  logic                   w_mac_en;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_wr_ok;
  logic signed [W-1:0]    w_y [N_OUT];

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_last   = (r_state == MAC) && (r_idx == IW'(N_IN - 1));
  assign w_wr_ok  = bus.w_wr_en && (r_state == IDLE) &&
                    ({1'b0, bus.w_addr} < (AW + 1)'(NW));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: one accepted vector, N_IN MAC cycles, then hold until downstream takes it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = MAC;
      MAC:     if (w_last) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; in_ready also waits for the first clock after reset release
  always_comb begin
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    w_out_valid = 1'b0;
    w_mac_en    = 1'b0;
    case (r_state)
      IDLE: w_in_ready = r_live;
      MAC: begin
        w_busy   = 1'b1;
        w_mac_en = 1'b1;
      end
      DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Holds in_ready low while reset is asserted and until the first clock after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // Input latch and input index: capture the vector on acceptance, then step one input per MAC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_relu <= 1'b0;
      for (int i = 0; i < N_IN; i++) r_x[i] <= '0;
    end else if (w_accept) begin
      r_idx  <= '0;
      r_relu <= bus.relu_en;
      for (int i = 0; i < N_IN; i++) r_x[i] <= bus.in_data[i*W +: W];
    end else if (w_mac_en && !w_last) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Weight file: writes land only while idle and in range; rejected writes flag an error next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
      for (int k = 0; k < NW; k++) r_w[k] <= '0;
    end else begin
      r_wr_err <= bus.w_wr_en && !w_wr_ok;
      if (w_wr_ok) r_w[bus.w_addr] <= bus.w_data;
    end
  end

  // Output register: loaded on the last MAC edge and held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
    end else if (w_last) begin
      for (int o = 0; o < N_OUT; o++) r_out_data[o*W +: W] <= w_y[o];
    end
  end

  generate
    for (genvar o = 0; o < N_OUT; o++) begin : g_lane
      logic [AW-1:0] w_widx;
      assign w_widx = AW'(o * N_IN) + AW'(r_idx);

      nn_mac_lane #(
        .W    (W),
        .FRAC (FRAC),
        .N_IN (N_IN)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_accept),
        .i_en    (w_mac_en),
        .i_relu  (r_relu),
        .i_x     (r_x[r_idx]),
        .i_w     (r_w[w_widx]),
        .o_y_out (w_y[o])
      );
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.w_wr_err  = r_wr_err;

endmodule

// File: tb/tb_nn_dense_layer.sv
// tb/tb_nn_dense_layer.sv - randomized self-checking bench against an arithmetic reference model
module tb_nn_dense_layer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk;
  int   n_err;

  logic [15:0] m_w0 [16];
  logic [15:0] m_w1 [3];
  logic [63:0] got0;
  logic [47:0] got1;

  int t1w [16] = '{3, 2, 13, 0, 0, 0, 0, 14, 3, 6, 0, 15, 9, 0, 15, 0};
  localparam logic [63:0] X1 = {16'd1, 16'd4, 16'd2, 16'd4};
  localparam logic [63:0] Y1 = {16'd96, 16'd39, 16'd14, 16'd68};

  always #5 clk = ~clk;

  nn_dense_layer_if #(.W(16), .N_IN(4), .N_OUT(4)) if0 ();
  nn_dense_layer_if #(.W(16), .N_IN(1), .N_OUT(3)) if1 ();

  nn_dense_layer #(.W(16), .FRAC(0), .N_IN(4), .N_OUT(4)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  nn_dense_layer #(.W(16), .FRAC(8), .N_IN(1), .N_OUT(3)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact sum, floor division by 2^frac, clamp to 16-bit signed, optional ReLU
  function automatic logic [15:0] ref_y(input longint sum, input int frac, input bit relu);
    longint d;
    longint r;
    d = longint'(1) << frac;
    if (sum >= 0) r = sum / d;
    else          r = -((-sum + d - 1) / d);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  function automatic logic [15:0] rand_word();
    if ($urandom_range(0, 1) == 1) return 16'($urandom);
    return 16'($urandom_range(0, 40)) - 16'd20;
  endfunction

  task automatic wr0(input int a, input logic [15:0] d);
    if0.w_wr_en = 1'b1;
    if0.w_addr  = 4'(a);
    if0.w_data  = d;
    @(negedge clk);
    if0.w_wr_en = 1'b0;
    chk("wr0 err", if0.w_wr_err, 0);
    m_w0[a] = d;
  endtask

  task automatic wr1(input int a, input logic [15:0] d);
    bit bad;
    bad = (a >= 3);
    if1.w_wr_en = 1'b1;
    if1.w_addr  = 2'(a);
    if1.w_data  = d;
    @(negedge clk);
    if1.w_wr_en = 1'b0;
    chk("wr1 err", if1.w_wr_err, 64'(bad));
    if (!bad) m_w1[a] = d;
  endtask

  task automatic run0(input logic [63:0] xv, input bit relu, input int hold,
                      input int bad_wr, input bit same_wr, input string tag);
    logic [63:0] e;
    logic [15:0] d;
    int cyc;
    int wa;
    if0.in_data   = xv;
    if0.relu_en   = relu;
    if0.in_valid  = 1'b1;
    if0.out_ready = 1'b0;
    cyc = 0;
    while (!if0.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " accept"}, 64'(cyc < 50), 1);
    if (same_wr) begin
      wa = $urandom_range(0, 15);
      d  = rand_word();
      if0.w_wr_en = 1'b1;
      if0.w_addr  = 4'(wa);
      if0.w_data  = d;
      m_w0[wa]    = d;
    end
    for (int o = 0; o < 4; o++) begin
      longint s;
      s = 0;
      for (int i = 0; i < 4; i++)
        s += longint'($signed(xv[i*16 +: 16])) * longint'($signed(m_w0[o*4 + i]));
      e[o*16 +: 16] = ref_y(s, 0, relu);
    end
    @(negedge clk);
    if0.in_valid = 1'b0;
    if (same_wr) begin
      if0.w_wr_en = 1'b0;
      chk({tag, " same-cycle wr err"}, if0.w_wr_err, 0);
    end
    cyc = 1;
    while (!if0.out_valid && cyc < 50) begin
      if (cyc == bad_wr) begin
        if0.w_wr_en = 1'b1;
        if0.w_addr  = 4'($urandom_range(0, 15));
        if0.w_data  = 16'h7777;
      end
      @(negedge clk);
      cyc++;
      if (if0.w_wr_en) begin
        if0.w_wr_en = 1'b0;
        chk({tag, " busy wr err"}, if0.w_wr_err, 1);
      end
    end
    chk({tag, " latency"}, cyc, 5);
    chk({tag, " y"}, if0.out_data, e);
    got0 = if0.out_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold y"}, if0.out_data, e);
      chk({tag, " hold valid"}, if0.out_valid, 1);
      chk({tag, " hold in_ready"}, if0.in_ready, 0);
      chk({tag, " hold busy"}, if0.busy, 1);
    end
    if0.out_ready = 1'b1;
    @(negedge clk);
    if0.out_ready = 1'b0;
    chk({tag, " post valid"}, if0.out_valid, 0);
    chk({tag, " post in_ready"}, if0.in_ready, 1);
    chk({tag, " post busy"}, if0.busy, 0);
    chk({tag, " post wr_err"}, if0.w_wr_err, 0);
  endtask

  task automatic run1(input logic [15:0] xv, input bit relu, input string tag);
    logic [47:0] e;
    int cyc;
    for (int o = 0; o < 3; o++)
      e[o*16 +: 16] = ref_y(longint'($signed(xv)) * longint'($signed(m_w1[o])), 8, relu);
    if1.in_data   = xv;
    if1.relu_en   = relu;
    if1.in_valid  = 1'b1;
    if1.out_ready = 1'b0;
    cyc = 0;
    while (!if1.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " accept"}, 64'(cyc < 50), 1);
    @(negedge clk);
    if1.in_valid = 1'b0;
    cyc = 1;
    while (!if1.out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, 2);
    chk({tag, " y"}, if1.out_data, e);
    got1 = if1.out_data;
    if1.out_ready = 1'b1;
    @(negedge clk);
    if1.out_ready = 1'b0;
    chk({tag, " post valid"}, if1.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] xr;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    if0.w_wr_en = 0; if0.w_addr = '0; if0.w_data = '0; if0.in_valid = 0;
    if0.in_data = '0; if0.relu_en = 0; if0.out_ready = 0;
    if1.w_wr_en = 0; if1.w_addr = '0; if1.w_data = '0; if1.in_valid = 0;
    if1.in_data = '0; if1.relu_en = 0; if1.out_ready = 0;
    for (int k = 0; k < 16; k++) m_w0[k] = '0;
    for (int k = 0; k < 3; k++) m_w1[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", if0.in_ready, 0);
    chk("rst out_valid", if0.out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel in_ready", if0.in_ready, 1);
    chk("rel out_valid", if0.out_valid, 0);
    chk("rel out_data", if0.out_data, 0);
    chk("rel busy", if0.busy, 0);
    chk("rel wr_err", if0.w_wr_err, 0);
    chk("rel u1 in_ready", if1.in_ready, 1);

    // Basic vector
    for (int k = 0; k < 16; k++) wr0(k, 16'(t1w[k]));
    run0(X1, 0, 0, 0, 0, "t1");
    chk("t1 literal", got0, Y1);

    // Saturation and ReLU on lane 0
    for (int k = 0; k < 16; k++) wr0(k, 16'd0);
    wr0(0, 16'd2);
    run0({48'd0, 16'h7FFF}, 0, 0, 0, 0, "t2sat");
    chk("t2 sat literal", got0[15:0], 16'h7FFF);
    wr0(0, 16'd1);
    run0({48'd0, 16'hFFFB}, 0, 0, 0, 0, "t2neg");
    chk("t2 neg literal", got0[15:0], 16'hFFFB);
    run0({48'd0, 16'hFFFB}, 1, 0, 0, 0, "t2relu");
    chk("t2 relu literal", got0[15:0], 16'h0000);

    // Backpressure, then write attempts while busy
    for (int k = 0; k < 16; k++) wr0(k, 16'(t1w[k]));
    run0(X1, 0, 6, 0, 0, "t4");
    chk("t4 literal", got0, Y1);
    run0(X1, 0, 0, 2, 0, "t5");
    chk("t5 literal", got0, Y1);
    run0(X1, 0, 0, 0, 0, "t5b");
    chk("t5b literal", got0, Y1);

    // Randomized vectors, weights, ReLU, backpressure and write timing
    for (int t = 0; t < 24; t++) begin
      repeat (3) wr0($urandom_range(0, 15), rand_word());
      for (int i = 0; i < 4; i++) xr[i*16 +: 16] = rand_word();
      run0(xr, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
           ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0,
           1'($urandom_range(0, 1)), "rnd");
    end

    // Reset during the second MAC cycle
    for (int k = 0; k < 16; k++) wr0(k, 16'(t1w[k]));
    if0.in_data = X1; if0.relu_en = 0; if0.in_valid = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6 out_valid", if0.out_valid, 0);
    chk("t6 in_ready", if0.in_ready, 0);
    chk("t6 busy", if0.busy, 0);
    chk("t6 out_data", if0.out_data, 0);
    chk("t6 wr_err", if0.w_wr_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) m_w0[k] = '0;
    for (int k = 0; k < 3; k++) m_w1[k] = '0;
    @(negedge clk);
    chk("t6 no partial", if0.out_valid, 0);
    run0(X1, 0, 0, 0, 0, "t6zero");
    chk("t6 zero weights", got0, 0);
    for (int k = 0; k < 16; k++) wr0(k, 16'(t1w[k]));
    run0(X1, 0, 0, 0, 0, "t6");
    chk("t6 literal", got0, Y1);

    // Fixed point, single-input engine, out-of-range weight address
    wr1(0, 16'h0200);
    wr1(1, 16'h0001);
    wr1(2, 16'h7FFF);
    run1(16'h0180, 0, "t3");
    chk("t3 literal", got1[15:0], 16'h0300);
    wr1(0, 16'h0001);
    run1(16'hFFFF, 0, "t3floor");
    chk("t3 floor literal", got1[15:0], 16'hFFFF);
    wr1(3, 16'h1234);
    run1(16'h0180, 0, "t5oor");
    chk("t5 oor literal", got1[15:0], 16'h0001);
    for (int t = 0; t < 10; t++) begin
      wr1($urandom_range(0, 3), rand_word());
      run1(rand_word(), 1'($urandom_range(0, 1)), "rnd1");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
